memory_arbiter: RTL and testbench

Sequences a single shared RAM port among the instruction and data caches of `CPUS` cores. It picks one pending cache request, holds it on the RAM port until RAM reports `ACCESS` (or `ERROR`), then releases that cache's wait for exactly one cycle. Data requests take priority over instruction requests. Within each class, cores are served round-robin. It sits between the per-core caches and the RAM model, in the memory-control layer of the processor.

---
 rtl/cpu_types_pkg.sv | 35 +++
 rtl/rr_picker.sv | 24 ++
 rtl/memory_arbiter.sv | 136 +++++++++++++
 tb/tb_memory_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared processor types used by the memory arbiter and its round-robin picker.
package cpu_types_pkg;

  // Core count the grant record is sized for; the arbiter's CPUS must match.
  localparam int ARB_CPUS = 2;
  localparam int CORE_W   = (ARB_CPUS > 1) ? $clog2(ARB_CPUS) : 1;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              isdata;
    logic              iswrite;
    word_t             addr;
    word_t             store;
  } arb_grant_t;

  // RAM has finished the current transaction, successfully or not.
  function automatic logic ram_done(ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after i_ptr, wrapping modulo CPUS.
module rr_picker #(
  parameter  int CPUS  = 2,
  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from farthest to nearest so the nearest requester after i_ptr wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = CPUS; k >= 1; k--) begin
      if (i_req[IDX_W'((int'(i_ptr) + k) % CPUS)]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'((int'(i_ptr) + k) % CPUS);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port among per-core icache/dcache requesters.
//
// state | meaning
// IDLE  | no grant held; picks a winner (data before instruction) when requests exist
// XFER  | registered grant drives the RAM port until ACCESS/ERROR or requester drop
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = ARB_CPUS
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  word_t [CPUS-1:0]   iaddr,
  input  word_t [CPUS-1:0]   daddr,
  input  word_t [CPUS-1:0]   dstore,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS-1:0]    dwait,
  output word_t [CPUS-1:0]   iload,
  output word_t [CPUS-1:0]   dload,
  output logic               ramREN,
  output logic               ramWEN,
  output word_t              ramaddr,
  output word_t              ramstore,
  input  word_t              ramload,
  input  ramstate_t          ramstate,
  output logic               ramerr
);

  localparam int IDX_W = CORE_W;

  arb_state_t        r_state, w_state_next;
  arb_grant_t        r_grant, w_grant_next;
  logic [IDX_W-1:0]  r_dptr, r_iptr, w_dptr_next, w_iptr_next;
  logic              r_ramerr, w_ramerr_next;

  logic [CPUS-1:0]   w_dreq;
  logic              w_dvalid, w_ivalid;
  logic [IDX_W-1:0]  w_didx, w_iidx;
  logic              w_held;

  assign w_dreq = dREN | dWEN;

  rr_picker #(.CPUS(CPUS)) u_dpick (
    .i_req   (w_dreq),
    .i_ptr   (r_dptr),
    .o_valid (w_dvalid),
    .o_idx   (w_didx)
  );

  rr_picker #(.CPUS(CPUS)) u_ipick (
    .i_req   (iREN),
    .i_ptr   (r_iptr),
    .o_valid (w_ivalid),
    .o_idx   (w_iidx)
  );

  // Granted requester still asserting the enable that won the grant.
  assign w_held = r_grant.isdata
                ? (r_grant.iswrite ? dWEN[r_grant.core] : dREN[r_grant.core])
                : iREN[r_grant.core];

  assign iload  = {CPUS{ramload}};
  assign dload  = {CPUS{ramload}};
  assign ramerr = r_ramerr;

  // State, grant record, class pointers and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_dptr   <= IDX_W'(CPUS - 1);
      r_iptr   <= IDX_W'(CPUS - 1);
      r_ramerr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_dptr   <= w_dptr_next;
      r_iptr   <= w_iptr_next;
      r_ramerr <= w_ramerr_next;
    end
  end

  // Next-state, grant selection and RAM/wait outputs.
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_dptr_next   = r_dptr;
    w_iptr_next   = r_iptr;
    w_ramerr_next = r_ramerr;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    iwait         = '1;
    dwait         = '1;

    case (r_state)
      IDLE: begin
        if (w_dvalid) begin
          w_grant_next = '{core: w_didx, isdata: 1'b1, iswrite: dWEN[w_didx],
                           addr: daddr[w_didx], store: dstore[w_didx]};
          w_state_next = XFER;
        end else if (w_ivalid) begin
          w_grant_next = '{core: w_iidx, isdata: 1'b0, iswrite: 1'b0,
                           addr: iaddr[w_iidx], store: '0};
          w_state_next = XFER;
        end
      end
      XFER: begin
        ramREN   = ~r_grant.iswrite;
        ramWEN   = r_grant.iswrite;
        ramaddr  = r_grant.addr;
        ramstore = r_grant.store;
        // Completion wins over a same-cycle enable drop: RAM already did the access.
        if (ram_done(ramstate)) begin
          if (r_grant.isdata) begin
            dwait[r_grant.core] = 1'b0;
            w_dptr_next         = r_grant.core;
          end else begin
            iwait[r_grant.core] = 1'b0;
            w_iptr_next         = r_grant.core;
          end
          if (ramstate == ERROR) w_ramerr_next = 1'b1;
          w_state_next = IDLE;
        end else if (!w_held) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration rules.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic             CLK;
  logic             RST;
  logic [CPUS-1:0]  iREN, dREN, dWEN;
  word_t [CPUS-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]  iwait, dwait;
  word_t [CPUS-1:0] iload, dload;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
  logic             ramerr;

  int n_err = 0;
  int n_chk = 0;

  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick(); #3;
    n_chk++; if (iwait !== 2'b11) begin n_err++; $display("FAIL reset_iwait: got %b expected 11", iwait); end
    n_chk++; if (dwait !== 2'b11) begin n_err++; $display("FAIL reset_dwait: got %b expected 11", dwait); end
    n_chk++; if ({ramREN, ramWEN} !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b expected 00", {ramREN, ramWEN}); end
    n_chk++; if (ramaddr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", ramaddr); end
    n_chk++; if (ramerr !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", ramerr); end
    tick(); RST = 1'b0; #3;
    tick(); #3;
    n_chk++; if ({iwait, dwait} !== 4'b1111) begin n_err++; $display("FAIL post_reset_waits: got %b expected 1111", {iwait, dwait}); end
    n_chk++; if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== 32'h0) begin
      n_err++; $display("FAIL post_reset_port: got en=%b addr=%h expected en=00 addr=0", {ramREN, ramWEN}, ramaddr);
    end
  endtask

  task automatic test_single_read();
    tick(); iREN = 2'b01; iaddr[0] = 32'h40; ramstate = FREE; #3;
    n_chk++; if (ramREN !== 1'b0) begin n_err++; $display("FAIL read_c0_ren: got %b expected 0", ramREN); end
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #3;
    n_chk++; if ({ramREN, ramWEN} !== 2'b10) begin n_err++; $display("FAIL read_c1_en: got %b expected 10", {ramREN, ramWEN}); end
    n_chk++; if (ramaddr !== 32'h40) begin n_err++; $display("FAIL read_c1_addr: got %h expected 40", ramaddr); end
    n_chk++; if ({iwait, dwait} !== 4'b1011) begin n_err++; $display("FAIL read_c1_waits: got %b expected 1011", {iwait, dwait}); end
    n_chk++; if (iload[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_c1_iload: got %h expected deadbeef", iload[0]); end
    tick(); iREN = '0; ramstate = FREE; #3;
    n_chk++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin
      n_err++; $display("FAIL read_c2: got iwait=%b ren=%b expected 11/0", iwait, ramREN);
    end
  endtask

  task automatic test_priority();
    tick(); iREN = 2'b01; iaddr[0] = 32'h80; dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'h5; #3;
    tick(); ramstate = ACCESS; #3;
    n_chk++; if ({ramREN, ramWEN} !== 2'b01) begin n_err++; $display("FAIL prio_write_en: got %b expected 01", {ramREN, ramWEN}); end
    n_chk++; if (ramaddr !== 32'h100 || ramstore !== 32'h5) begin
      n_err++; $display("FAIL prio_write_port: got addr=%h store=%h expected 100/5", ramaddr, ramstore);
    end
    n_chk++; if ({iwait, dwait} !== 4'b1101) begin n_err++; $display("FAIL prio_write_waits: got %b expected 1101", {iwait, dwait}); end
    tick(); dWEN = '0; ramstate = FREE; #3;
    n_chk++; if ({ramREN, ramWEN, iwait, dwait} !== 6'b001111) begin
      n_err++; $display("FAIL prio_gap: got %b expected 001111", {ramREN, ramWEN, iwait, dwait});
    end
    tick(); ramstate = ACCESS; ramload = 32'hCAFE0000; #3;
    n_chk++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h80) begin
      n_err++; $display("FAIL prio_fetch_port: got en=%b addr=%h expected 10/80", {ramREN, ramWEN}, ramaddr);
    end
    n_chk++; if ({iwait, dwait} !== 4'b1011) begin n_err++; $display("FAIL prio_fetch_waits: got %b expected 1011", {iwait, dwait}); end
    tick(); iREN = '0; ramstate = FREE; #3;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_dw;
    word_t      exp_a;
    tick(); dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300; ramstate = ACCESS; #3;
    for (int k = 0; k < 4; k++) begin
      exp_dw = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a  = (k % 2 == 0) ? 32'h200 : 32'h300;
      tick(); #3;
      n_chk++; if (ramREN !== 1'b1 || ramaddr !== exp_a || dwait !== exp_dw) begin
        n_err++; $display("FAIL rr_grant%0d: got ren=%b addr=%h dwait=%b expected 1/%h/%b", k, ramREN, ramaddr, dwait, exp_a, exp_dw);
      end
      tick(); if (k == 3) dREN = '0; #3;
      n_chk++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin
        n_err++; $display("FAIL rr_gap%0d: got ren=%b dwait=%b expected 0/11", k, ramREN, dwait);
      end
    end
    ramstate = FREE;
  endtask

  task automatic test_stall();
    tick(); dREN = 2'b10; daddr[1] = 32'h444; ramstate = FREE; #3;
    for (int b = 1; b <= 3; b++) begin
      tick(); ramstate = BUSY; #3;
      n_chk++; if (ramREN !== 1'b1 || dwait !== 2'b11) begin
        n_err++; $display("FAIL stall_busy%0d: got ren=%b dwait=%b expected 1/11", b, ramREN, dwait);
      end
    end
    tick(); ramstate = ACCESS; ramload = 32'h1234; #3;
    n_chk++; if (dwait !== 2'b01 || dload[1] !== 32'h1234) begin
      n_err++; $display("FAIL stall_done: got dwait=%b dload=%h expected 01/1234", dwait, dload[1]);
    end
    tick(); dREN = '0; ramstate = FREE; #3;
    n_chk++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin
      n_err++; $display("FAIL stall_after: got dwait=%b ren=%b expected 11/0", dwait, ramREN);
    end
  endtask

  task automatic test_abort();
    tick(); dREN = 2'b01; daddr[0] = 32'h500; #3;
    tick(); ramstate = BUSY; #3;
    n_chk++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      n_err++; $display("FAIL abort_xfer: got ren=%b addr=%h expected 1/500", ramREN, ramaddr);
    end
    tick(); dREN = '0; #3;
    n_chk++; if (dwait !== 2'b11) begin n_err++; $display("FAIL abort_drop_wait: got %b expected 11", dwait); end
    tick(); ramstate = FREE; dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700; #3;
    n_chk++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin
      n_err++; $display("FAIL abort_idle: got ren=%b dwait=%b expected 0/11", ramREN, dwait);
    end
    tick(); ramstate = ACCESS; #3;
    n_chk++; if (ramaddr !== 32'h600 || dwait !== 2'b10) begin
      n_err++; $display("FAIL abort_no_ptr_update: got addr=%h dwait=%b expected 600/10", ramaddr, dwait);
    end
    tick(); dREN = '0; ramstate = FREE; #3;
  endtask

  task automatic test_reset_mid();
    tick(); iREN = 2'b10; iaddr[1] = 32'h700; #3;
    tick(); ramstate = BUSY; #3;
    n_chk++; if (ramREN !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got ren=%b expected 1", ramREN); end
    #1 RST = 1'b1;
    #1;
    n_chk++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 2'b11) begin
      n_err++; $display("FAIL rstmid_async: got ren=%b addr=%h iwait=%b expected 0/0/11", ramREN, ramaddr, iwait);
    end
    tick(); iREN = '0; ramstate = FREE; RST = 1'b0; #3;
    n_chk++; if (ramREN !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got ren=%b expected 0", ramREN); end
  endtask

  task automatic test_error();
    tick(); dREN = 2'b01; daddr[0] = 32'h800; #3;
    tick(); ramstate = ERROR; #3;
    n_chk++; if (dwait !== 2'b10 || ramerr !== 1'b0) begin
      n_err++; $display("FAIL err_pulse: got dwait=%b err=%b expected 10/0", dwait, ramerr);
    end
    tick(); dREN = '0; ramstate = FREE; #3;
    n_chk++; if (ramerr !== 1'b1 || dwait !== 2'b11) begin
      n_err++; $display("FAIL err_set: got err=%b dwait=%b expected 1/11", ramerr, dwait);
    end
    tick(); iREN = 2'b01; #3;
    tick(); ramstate = ACCESS; #3;
    n_chk++; if (iwait !== 2'b10 || ramerr !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got iwait=%b err=%b expected 10/1", iwait, ramerr);
    end
    tick(); iREN = '0; ramstate = FREE; RST = 1'b1; #3;
    n_chk++; if (ramerr !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", ramerr); end
    tick(); RST = 1'b0; #3;
  endtask

  // Randomized traffic against a transaction-level model of the arbitration rules.
  task automatic test_random();
    logic [CPUS-1:0] pend_i, pend_dr, pend_dw;
    logic            m_busy, m_isdata, m_wr, m_err, found, done;
    int              m_core, m_dptr, m_iptr, c, kind, r;
    word_t           m_addr, m_store;
    logic [CPUS-1:0] exp_iw, exp_dw;

    tick(); RST = 1'b1; clear_inputs();
    tick(); RST = 1'b0;
    pend_i = '0; pend_dr = '0; pend_dw = '0;
    m_busy = 1'b0; m_isdata = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    m_core = 0; m_dptr = CPUS - 1; m_iptr = CPUS - 1;
    m_addr = '0; m_store = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int k = 0; k < CPUS; k++) begin
        if (!pend_i[k] && $urandom_range(0, 3) == 0) begin
          pend_i[k] = 1'b1; iaddr[k] = $urandom;
        end
        if (!(pend_dr[k] | pend_dw[k]) && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          pend_dr[k] = (kind != 1); pend_dw[k] = (kind != 0);
          daddr[k] = $urandom; dstore[k] = $urandom;
        end
      end
      iREN = pend_i; dREN = pend_dr; dWEN = pend_dw;
      ramload = $urandom;
      if (m_busy) begin
        r = $urandom_range(0, 9);
        ramstate = (r < 5) ? BUSY : ((r == 9) ? ERROR : ACCESS);
      end else begin
        ramstate = ($urandom_range(0, 1) == 0) ? FREE : BUSY;
      end
      #3;

      done = m_busy && (ramstate == ACCESS || ramstate == ERROR);
      exp_iw = '1; exp_dw = '1;
      if (done) begin
        if (m_isdata) exp_dw[m_core] = 1'b0; else exp_iw[m_core] = 1'b0;
      end
      n_chk++; if ({ramREN, ramWEN} !== {m_busy & ~m_wr, m_busy & m_wr}) begin
        n_err++; $display("FAIL rnd_en cyc%0d: got %b expected %b", cyc, {ramREN, ramWEN}, {m_busy & ~m_wr, m_busy & m_wr});
      end
      n_chk++; if (iwait !== exp_iw || dwait !== exp_dw) begin
        n_err++; $display("FAIL rnd_waits cyc%0d: got i=%b d=%b expected i=%b d=%b", cyc, iwait, dwait, exp_iw, exp_dw);
      end
      n_chk++; if (ramerr !== m_err) begin
        n_err++; $display("FAIL rnd_err cyc%0d: got %b expected %b", cyc, ramerr, m_err);
      end
      if (m_busy) begin
        n_chk++; if (ramaddr !== m_addr) begin
          n_err++; $display("FAIL rnd_addr cyc%0d: got %h expected %h", cyc, ramaddr, m_addr);
        end
        if (m_wr) begin
          n_chk++; if (ramstore !== m_store) begin
            n_err++; $display("FAIL rnd_store cyc%0d: got %h expected %h", cyc, ramstore, m_store);
          end
        end
      end
      if (done) begin
        n_chk++; if ((m_isdata ? dload[m_core] : iload[m_core]) !== ramload) begin
          n_err++; $display("FAIL rnd_load cyc%0d: got %h expected %h", cyc, m_isdata ? dload[m_core] : iload[m_core], ramload);
        end
      end

      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= CPUS; k++) begin
          c = (m_dptr + k) % CPUS;
          if (!found && (dREN[c] || dWEN[c])) begin
            found = 1'b1; m_busy = 1'b1; m_isdata = 1'b1; m_wr = dWEN[c];
            m_core = c; m_addr = daddr[c]; m_store = dstore[c];
          end
        end
        for (int k = 1; k <= CPUS; k++) begin
          c = (m_iptr + k) % CPUS;
          if (!found && iREN[c]) begin
            found = 1'b1; m_busy = 1'b1; m_isdata = 1'b0; m_wr = 1'b0;
            m_core = c; m_addr = iaddr[c]; m_store = '0;
          end
        end
      end else if (done) begin
        if (ramstate == ERROR) m_err = 1'b1;
        if (m_isdata) begin
          m_dptr = m_core; pend_dr[m_core] = 1'b0; pend_dw[m_core] = 1'b0;
        end else begin
          m_iptr = m_core; pend_i[m_core] = 1'b0;
        end
        m_busy = 1'b0;
      end
    end
    tick(); clear_inputs(); #3;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_stall();
    test_abort();
    test_reset_mid();
    test_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
